// File: rtl/dma_block_mover.sv
// rtl/dma_block_mover.sv - DVK block-copy DMA channel; optional pattern fill via DMA_BLOCK_MOVER_FILL_EN
module dma_block_mover #(
  parameter int         BURST   = 4,
  parameter int         TIMEOUT = 255,
  parameter logic [8:0] VECTOR  = 9'o270
) (
  input  logic        clk_p,
  input  logic        rst_n,
  input  logic        bus_reset,
  input  logic [1:0]  wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        dma_req,
  input  logic        dma_ack,
  output logic [17:0] dma_adr18,
  output logic        dma_stb,
  output logic        dma_we,
  output logic [15:0] dma_dat_o,
  input  logic [15:0] dma_dat_i,
  input  logic        dma_reply,
  output logic        irq,
  input  logic        istb,
  output logic        iack,
  output logic [8:0]  ivec
);

  localparam logic [15:0] BURST_W = 16'(BURST);
  localparam logic [15:0] TMO_W   = 16'(TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_RD, S_GAP1, S_WR, S_NEXT, S_REL, S_ABORT, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] src_q, src_d, dst_q, dst_d, wc_q, wc_d, data_q, data_d;
  logic [1:0]  src_ext_q, src_ext_d, dst_ext_q, dst_ext_d;
  logic [15:0] burst_q, burst_d, tmo_q, tmo_d, rdat_q, rdat_d;
  logic        ie_q, ie_d, err_q, err_d, irq_q, irq_d, iack_q, iack_d, ack_q, ack_d;
  logic        rd_latch, nxt, tmo_run, abort_set, done_pulse;
  logic        fill;
`ifdef DMA_BLOCK_MOVER_FILL_EN
  logic        fill_q, fill_d;
  assign fill = fill_q;
`else
  assign fill = 1'b0;
`endif

  function automatic logic [15:0] merge_bytes(input logic [15:0] old_v, input logic [15:0] new_v,
                                               input logic [1:0] sel);
    merge_bytes = {sel[1] ? new_v[15:8] : old_v[15:8], sel[0] ? new_v[7:0] : old_v[7:0]};
  endfunction

  // One register write per slave access: the cycle before our own reply
  logic        wb_access, csr_wr, src_wr, dst_wr, wc_wr, rdy, go;
  logic [15:0] wc_inc, csr_val;
  assign wb_access = wb_stb_i & ~ack_q;
  assign csr_wr    = wb_access & wb_we_i & (wb_adr_i == 2'd0);
  assign src_wr    = wb_access & wb_we_i & (wb_adr_i == 2'd1);
  assign dst_wr    = wb_access & wb_we_i & (wb_adr_i == 2'd2);
  assign wc_wr     = wb_access & wb_we_i & (wb_adr_i == 2'd3);
  assign rdy       = (state_q == S_IDLE) | (state_q == S_DONE);
  assign go        = csr_wr & wb_sel_i[0] & wb_dat_i[0] & rdy;
  assign wc_inc    = wc_q + 16'd1;
  assign csr_val   = {err_q, 3'b000, dst_ext_q, 2'b00, rdy, ie_q, src_ext_q, fill, 3'b000};

  assign wb_ack_o = ack_q;
  assign wb_dat_o = rdat_q;
  assign irq      = irq_q;
  assign iack     = iack_q;
  assign ivec     = iack_q ? VECTOR : 9'd0;

  // FSM state register
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and bus outputs; strobes are gated by the grant
  always_comb begin
    state_d    = state_q;
    dma_req    = 1'b0;
    dma_stb    = 1'b0;
    dma_we     = 1'b0;
    dma_adr18  = 18'd0;
    dma_dat_o  = 16'd0;
    rd_latch   = 1'b0;
    nxt        = 1'b0;
    tmo_run    = 1'b0;
    abort_set  = 1'b0;
    done_pulse = 1'b0;
    case (state_q)
      S_IDLE: if (go) state_d = S_REQ;
      S_REQ: begin
        dma_req = 1'b1;
        if (dma_ack) state_d = fill ? S_WR : S_RD;
      end
      S_RD: begin
        dma_req   = 1'b1;
        dma_adr18 = {src_ext_q, src_q};
        if (dma_ack) begin
          dma_stb = 1'b1;
          if (dma_reply) begin
            rd_latch = 1'b1;
            state_d  = S_GAP1;
          end else if (tmo_q == TMO_W) state_d = S_ABORT;
          else tmo_run = 1'b1;
        end
      end
      S_GAP1: begin
        dma_req = 1'b1;
        state_d = S_WR;
      end
      S_WR: begin
        dma_req   = 1'b1;
        dma_we    = 1'b1;
        dma_adr18 = {dst_ext_q, dst_q};
        dma_dat_o = fill ? src_q : data_q;
        if (dma_ack) begin
          dma_stb = 1'b1;
          if (dma_reply) state_d = S_NEXT;
          else if (tmo_q == TMO_W) state_d = S_ABORT;
          else tmo_run = 1'b1;
        end
      end
      S_NEXT: begin
        dma_req = 1'b1;
        nxt     = 1'b1;
        if (wc_inc == 16'd0) state_d = S_DONE;
        else if (burst_q + 16'd1 == BURST_W) state_d = S_REL;
        else state_d = fill ? S_WR : S_RD;
      end
      S_REL:   state_d = S_REQ;
      S_ABORT: begin
        abort_set = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE: begin
        done_pulse = 1'b1;
        state_d    = go ? S_REQ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus_reset) state_d = S_IDLE;
  end

  // Register file, address counters, timeout, interrupt and slave reply next-state
  always_comb begin
    src_d = src_q;  src_ext_d = src_ext_q;  dst_d = dst_q;  dst_ext_d = dst_ext_q;
    wc_d = wc_q;  ie_d = ie_q;  err_d = err_q;  data_d = data_q;  burst_d = burst_q;
    irq_d = irq_q;  rdat_d = rdat_q;
`ifdef DMA_BLOCK_MOVER_FILL_EN
    fill_d = fill_q;
    if (csr_wr & rdy & wb_sel_i[0]) fill_d = wb_dat_i[3];
`endif
    if (rdy) begin
      if (src_wr) src_d = merge_bytes(src_q, wb_dat_i, wb_sel_i) & 16'hFFFE;
      if (dst_wr) dst_d = merge_bytes(dst_q, wb_dat_i, wb_sel_i) & 16'hFFFE;
      if (wc_wr)  wc_d  = merge_bytes(wc_q, wb_dat_i, wb_sel_i);
      if (csr_wr & wb_sel_i[0]) src_ext_d = wb_dat_i[5:4];
      if (csr_wr & wb_sel_i[1]) dst_ext_d = wb_dat_i[11:10];
    end
    if (csr_wr & wb_sel_i[0]) ie_d = wb_dat_i[6];
    if (go)        err_d  = 1'b0;
    if (abort_set) err_d  = 1'b1;
    if (rd_latch)  data_d = dma_dat_i;
    if (nxt) begin
      {dst_ext_d, dst_d} = {dst_ext_q, dst_q} + 18'd2;
      if (!fill) {src_ext_d, src_d} = {src_ext_q, src_q} + 18'd2;
      wc_d    = wc_inc;
      burst_d = burst_q + 16'd1;
    end
    if (state_q == S_REQ) burst_d = 16'd0;
    tmo_d = (state_d != state_q) ? 16'd0 : (tmo_run ? tmo_q + 16'd1 : tmo_q);
    if (csr_wr & wb_sel_i[0] & ~wb_dat_i[6]) irq_d = 1'b0;
    else if ((csr_wr & wb_sel_i[0] & wb_dat_i[6] & ~ie_q & rdy) | (done_pulse & ie_q)) irq_d = 1'b1;
    else if (istb & irq_q) irq_d = 1'b0;
    iack_d = istb & irq_q;
    ack_d  = wb_stb_i & ~ack_q;
    if (wb_access) begin
      case (wb_adr_i)
        2'd0:    rdat_d = csr_val;
        2'd1:    rdat_d = src_q;
        2'd2:    rdat_d = dst_q;
        default: rdat_d = wc_q;
      endcase
    end
    if (bus_reset) begin
      src_d = '0;  src_ext_d = '0;  dst_d = '0;  dst_ext_d = '0;  wc_d = '0;  ie_d = 1'b0;
      err_d = 1'b0;  data_d = '0;  burst_d = '0;  tmo_d = '0;  irq_d = 1'b0;  iack_d = 1'b0;
      ack_d = 1'b0;  rdat_d = '0;
`ifdef DMA_BLOCK_MOVER_FILL_EN
      fill_d = 1'b0;
`endif
    end
  end

  // Datapath register bank
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;  src_ext_q <= '0;  dst_q <= '0;  dst_ext_q <= '0;  wc_q <= '0;  ie_q <= 1'b0;
      err_q <= 1'b0;  data_q <= '0;  burst_q <= '0;  tmo_q <= '0;  irq_q <= 1'b0;  iack_q <= 1'b0;
      ack_q <= 1'b0;  rdat_q <= '0;
`ifdef DMA_BLOCK_MOVER_FILL_EN
      fill_q <= 1'b0;
`endif
    end else begin
      src_q <= src_d;  src_ext_q <= src_ext_d;  dst_q <= dst_d;  dst_ext_q <= dst_ext_d;  wc_q <= wc_d;
      ie_q <= ie_d;  err_q <= err_d;  data_q <= data_d;  burst_q <= burst_d;  tmo_q <= tmo_d;
      irq_q <= irq_d;  iack_q <= iack_d;  ack_q <= ack_d;  rdat_q <= rdat_d;
`ifdef DMA_BLOCK_MOVER_FILL_EN
      fill_q <= fill_d;
`endif
    end
  end

endmodule

// File: tb/tb_dma_block_mover.sv
// tb/tb_dma_block_mover.sv - randomized bench for dma_block_mover against a memory-level copy model
module tb_dma_block_mover;
  localparam int BURST = 4;

  logic        clk_p = 1'b0;
  logic        rst_n, bus_reset;
  logic [1:0]  wb_adr_i, wb_sel_i;
  logic [15:0] wb_dat_i, wb_dat_o, dma_dat_o, dma_dat_i;
  logic        wb_we_i, wb_stb_i, wb_ack_o;
  logic        dma_req, dma_ack, dma_stb, dma_we, dma_reply;
  logic [17:0] dma_adr18;
  logic        irq, istb, iack;
  logic [8:0]  ivec;

  always #5 clk_p = ~clk_p;

  dma_block_mover #(.BURST(BURST), .TIMEOUT(255), .VECTOR(9'o270)) dut (
    .clk_p(clk_p), .rst_n(rst_n), .bus_reset(bus_reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o),
    .dma_req(dma_req), .dma_ack(dma_ack), .dma_adr18(dma_adr18), .dma_stb(dma_stb),
    .dma_we(dma_we), .dma_dat_o(dma_dat_o), .dma_dat_i(dma_dat_i), .dma_reply(dma_reply),
    .irq(irq), .istb(istb), .iack(iack), .ivec(ivec)
  );

  typedef struct packed {
    logic        we;
    logic [17:0] adr;
    logic [15:0] dat;
  } txn_t;

  int   n_vec = 0, n_err = 0;
  logic [15:0] mem [logic [17:0]];
  txn_t obs_q[$];
  bit   jitter = 0, no_reply = 0, in_xfer = 0, low_active = 0;
  int   cnt = 0, writes_done = 0, rel_cnt = 0, low_len = 0;
  logic prev_req = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] init_val(input logic [17:0] a);
    return a[15:0] ^ 16'hA5C3 ^ {14'd0, a[17:16]};
  endfunction

  // Memory slave on the DMA side: grants, 2-cycle replies, optional grant jitter
  initial begin
    dma_ack = 1'b0; dma_reply = 1'b0; dma_dat_i = 16'd0;
    forever begin
      @(negedge clk_p);
      if (dma_req && !dma_ack) check_eq("stb_without_ack", dma_stb, 1'b0);
      if (in_xfer) begin
        if (prev_req && !dma_req) begin low_active = 1; low_len = 0; end
        if (low_active && !dma_req) low_len++;
        if (low_active && dma_req) begin
          check_eq("release_len", low_len, 1);
          check_eq("release_pos", writes_done % BURST, 0);
          rel_cnt++;
          low_active = 0;
        end
      end
      prev_req = dma_req;
      if (dma_reply) begin
        dma_reply = 1'b0; cnt = 0;
      end else if (!dma_stb) cnt = 0;
      else if (!no_reply) begin
        cnt++;
        if (cnt == 2) begin
          dma_reply = 1'b1;
          if (dma_we) begin
            mem[dma_adr18] = dma_dat_o;
            obs_q.push_back(txn_t'({1'b1, dma_adr18, dma_dat_o}));
            writes_done++;
          end else begin
            dma_dat_i = mem.exists(dma_adr18) ? mem[dma_adr18] : init_val(dma_adr18);
            obs_q.push_back(txn_t'({1'b0, dma_adr18, dma_dat_i}));
          end
        end
      end
      if (!dma_req) dma_ack = 1'b0;
      else if (cnt == 0 && !dma_reply) dma_ack = jitter ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic wb_cycle(input logic [1:0] adr, input logic [15:0] dat, input logic we,
                          output logic [15:0] rd);
    int t = 0;
    @(negedge clk_p);
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = 2'b11; wb_we_i = we; wb_stb_i = 1'b1;
    do begin @(negedge clk_p); t++; end while (!wb_ack_o && t < 20);
    if (!wb_ack_o) check_eq("wb_ack_timeout", wb_ack_o, 1'b1);
    rd = wb_dat_o;
    wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [15:0] dat);
    logic [15:0] dummy;
    wb_cycle(adr, dat, 1'b1, dummy);
  endtask

  task automatic wb_read(input logic [1:0] adr, output logic [15:0] dat);
    wb_cycle(adr, 16'd0, 1'b0, dat);
  endtask

  task automatic run_xfer(input logic [15:0] src, input logic [1:0] sext, input logic [15:0] dst,
                          input logic [1:0] dext, input int n, input bit ie, input bit fill);
    logic [15:0] ref_mem [logic [17:0]];
    txn_t        exp_q[$];
    logic [17:0] s, d;
    logic [15:0] v, rd;
    int          polls = 0;
    ref_mem = mem;
    s = {sext, src}; d = {dext, dst};
    for (int i = 0; i < n; i++) begin
      if (fill) v = src;
      else begin
        v = ref_mem.exists(s) ? ref_mem[s] : init_val(s);
        exp_q.push_back(txn_t'({1'b0, s, v}));
        s = s + 18'd2;
      end
      exp_q.push_back(txn_t'({1'b1, d, v}));
      ref_mem[d] = v;
      d = d + 18'd2;
    end
    obs_q.delete(); writes_done = 0; rel_cnt = 0; low_active = 0; in_xfer = 1;
    wb_write(2'd1, src); wb_write(2'd2, dst); wb_write(2'd3, 16'(0 - n));
    wb_write(2'd0, {4'b0, dext, 3'b0, ie, sext, fill, 2'b0, 1'b1});
    rd = 16'd0;
    while (!rd[7] && polls < 3000) begin wb_read(2'd0, rd); polls++; end
    check_eq("xfer_finished", rd[7], 1'b1);
    repeat (2) @(negedge clk_p);
    in_xfer = 0;
    check_eq("txn_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) check_eq("txn", obs_q[i], exp_q[i]);
    check_eq("release_count", rel_cnt, (n - 1) / BURST);
    wb_read(2'd1, rd); check_eq("final_src", rd, s[15:0]);
    wb_read(2'd2, rd); check_eq("final_dst", rd, d[15:0]);
    wb_read(2'd3, rd); check_eq("final_wc", rd, 16'd0);
    wb_read(2'd0, rd);
    check_eq("final_csr", rd, {1'b0, 3'b0, d[17:16], 2'b0, 1'b1, ie, s[17:16], fill, 3'b0});
    check_eq("final_irq", irq, ie);
    check_eq("final_req", dma_req, 1'b0);
  endtask

  task automatic irq_acknowledge();
    check_eq("irq_before_istb", irq, 1'b1);
    @(negedge clk_p); istb = 1'b1;
    @(negedge clk_p);
    check_eq("iack", iack, 1'b1); check_eq("ivec", ivec, 9'o270); check_eq("irq_after_iack", irq, 1'b0);
    istb = 1'b0;
    @(negedge clk_p);
    check_eq("iack_one_cycle", iack, 1'b0); check_eq("ivec_idle", ivec, 9'd0);
  endtask

  task automatic start_until_write();
    int t = 0;
    jitter = 0;
    wb_write(2'd0, 16'h0000);
    wb_write(2'd1, 16'o6000); wb_write(2'd2, 16'o7000); wb_write(2'd3, 16'o177770);
    wb_write(2'd0, 16'h0041);
    check_eq("irq_set_by_ie", irq, 1'b1);
    while (!(dma_stb && dma_we) && t < 500) begin @(negedge clk_p); t++; end
    check_eq("reached_write", dma_stb & dma_we, 1'b1);
  endtask

  initial begin
    logic [15:0] rd;
    int          t;
    rst_n = 1'b0; bus_reset = 1'b0; istb = 1'b0;
    wb_adr_i = 2'd0; wb_dat_i = 16'd0; wb_sel_i = 2'b00; wb_we_i = 1'b0; wb_stb_i = 1'b0;
    repeat (3) @(negedge clk_p);
    check_eq("reset_req", dma_req, 1'b0); check_eq("reset_stb", dma_stb, 1'b0);
    check_eq("reset_irq", irq, 1'b0);     check_eq("reset_ivec", ivec, 9'd0);
    rst_n = 1'b1;
    wb_read(2'd0, rd); check_eq("reset_csr", rd, 16'o000200);
    wb_read(2'd1, rd); check_eq("reset_src", rd, 16'd0);
    wb_read(2'd3, rd); check_eq("reset_wc", rd, 16'd0);

    run_xfer(16'o1000, 2'd0, 16'o2000, 2'd0, 3, 1'b1, 1'b0);
    irq_acknowledge();
    @(negedge clk_p); istb = 1'b1;
    @(negedge clk_p); check_eq("stray_istb", iack, 1'b0);
    istb = 1'b0;

    jitter = 1;
    run_xfer(16'o3000, 2'd1, 16'o4000, 2'd2, 10, 1'b0, 1'b0);
    jitter = 0;
    run_xfer(16'o177776, 2'd3, 16'o3000, 2'd0, 1, 1'b0, 1'b0);
    check_eq("wrap_read_addr", obs_q[0].adr, 18'o777776);

    jitter = 1;
    for (int k = 0; k < 12; k++) begin
      bit ie_r = 1'($urandom_range(0, 1));
      run_xfer(16'($urandom) & 16'hFFFE, 2'($urandom), 16'($urandom) & 16'hFFFE, 2'($urandom),
               int'($urandom_range(1, 12)), ie_r, 1'b0);
      if (ie_r) irq_acknowledge();
    end
    jitter = 0;

    wb_write(2'd0, 16'h0000);
    no_reply = 1;
    wb_write(2'd1, 16'o4000); wb_write(2'd2, 16'o5000); wb_write(2'd3, 16'o177775);
    wb_write(2'd0, 16'h0001);
    t = 0;
    while (!dma_stb && t < 100) begin @(negedge clk_p); t++; end
    t = 0;
    while (dma_stb && t < 1000) begin @(negedge clk_p); t++; end
    check_eq("timeout_stb_cycles", t, 256);
    repeat (4) @(negedge clk_p);
    wb_read(2'd0, rd); check_eq("timeout_csr", rd, 16'h8080);
    check_eq("timeout_req", dma_req, 1'b0); check_eq("timeout_irq", irq, 1'b0);
    wb_read(2'd1, rd); check_eq("timeout_src", rd, 16'o4000);
    wb_read(2'd3, rd); check_eq("timeout_wc", rd, 16'o177775);
    no_reply = 0;
    run_xfer(16'o1234, 2'd0, 16'o4320, 2'd1, 2, 1'b0, 1'b0);

    start_until_write();
    #2 rst_n = 1'b0;
    #1 check_eq("arst_stb", dma_stb, 1'b0); check_eq("arst_req", dma_req, 1'b0);
    check_eq("arst_irq", irq, 1'b0);
    @(negedge clk_p); rst_n = 1'b1;
    wb_read(2'd0, rd); check_eq("arst_csr", rd, 16'o000200);
    wb_read(2'd1, rd); check_eq("arst_src", rd, 16'd0);

    start_until_write();
    bus_reset = 1'b1;
    @(posedge clk_p); #1;
    check_eq("brst_stb", dma_stb, 1'b0); check_eq("brst_req", dma_req, 1'b0);
    check_eq("brst_irq", irq, 1'b0);
    @(negedge clk_p); bus_reset = 1'b0;
    wb_read(2'd0, rd); check_eq("brst_csr", rd, 16'o000200);

`ifdef DMA_BLOCK_MOVER_FILL_EN
    run_xfer(16'o125252, 2'd0, 16'o2000, 2'd0, 2, 1'b0, 1'b1);
`else
    wb_write(2'd0, 16'h0008);
    wb_read(2'd0, rd); check_eq("fill_bit_absent", rd, 16'h0080);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time budget exhausted");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dma_block_mover.md
Name: dma_block_mover

Overview:
- Register-programmed memory-to-memory block copy channel for the DVK bus.
- Acts as a Wishbone slave for its four control registers.
- Acts as an 18-bit UNIBUS-style DMA master toward the CPU board: dma_req, dma_ack, dma_adr18, dma_stb and the global reply, translated by the board's UMR.
- Raises a vectored interrupt on completion and answers the CPU's vector strobe.

Parameters:
- BURST, 4: words moved per bus tenure before dma_req is released.
- TIMEOUT, 255: cycles to wait for a DMA reply before aborting.
- VECTOR, 9'o270: interrupt vector returned on acknowledge.

Ports:
- clk_p  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bus_reset  in  1  synchronous active-high bus INIT; same effect as reset.
- wb_adr_i  in  2  register select (word offset 0..3).
- wb_dat_i  in  16  slave write data.
- wb_dat_o  out  16  slave read data.
- wb_we_i  in  1  slave write enable.
- wb_sel_i  in  2  byte selects.
- wb_stb_i  in  1  slave strobe (decoded by the board).
- wb_ack_o  out  1  slave reply.
- dma_req  out  1  bus request.
- dma_ack  in  1  bus grant.
- dma_adr18  out  18  UNIBUS address.
- dma_stb  out  1  DMA data strobe.
- dma_we  out  1  DMA write (1) / read (0).
- dma_dat_o  out  16  DMA write data.
- dma_dat_i  in  16  DMA read data.
- dma_reply  in  1  DMA cycle acknowledge (global ack).
- irq  out  1  interrupt request.
- istb  in  1  vector strobe from CPU.
- iack  out  1  vector acknowledge.
- ivec  out  9  vector; VECTOR while iack is high, else 0.

Behaviour:
- Reset (rst_n low, asynchronous; bus_reset, synchronous):
  - All outputs 0, FSM to IDLE.
  - SRC, DST, WC = 0; CSR reads 000200 (RDY=1).
  - Any transfer in progress aborts immediately; dma_req drops in the same cycle.
- Registers (offset 0 CSR, 1 SRC, 2 DST, 3 WC):
  - Byte writes honour wb_sel_i.
  - Reply: wb_ack_o <= wb_stb_i & ~wb_ack_o. Read data is held while wb_stb_i is high.
- CSR bits:
  - 0 GO: write-1 starts a transfer; always reads 0.
  - 5:4 SRC A17:16.
  - 6 IE.
  - 7 RDY: read-only; 1 when idle.
  - 11:10 DST A17:16.
  - 15 ERR: read-only; cleared by GO.
  - Other bits read 0.
- SRC/DST: bit 0 is forced to 0.
- WC is two's-complement negative word count. WC=0 at GO moves 65536 words.
- Writes while RDY=0: ignored for SRC, DST, WC, GO and the extension bits. IE is always writable.
- FSM:
  - IDLE: GO & RDY -> REQ. RDY clears, ERR clears.
  - REQ: dma_req=1; wait for dma_ack -> RD.
  - RD: dma_adr18={ext,SRC}, dma_we=0, dma_stb=1. On dma_reply latch dma_dat_i and go to GAP1. No reply for TIMEOUT+1 cycles -> ABORT.
  - GAP1: stb=0 for one cycle -> WR.
  - WR: dma_adr18={ext,DST}, dma_we=1, dma_dat_o=latched data, dma_stb=1. On reply -> NEXT. Same timeout -> ABORT.
  - NEXT: SRC+=2, DST+=2, with carry into their 2-bit extensions (18-bit wrap 777776->0); WC+=1.
    - WC becomes 0 -> DONE.
    - Else if words this tenure == BURST -> REL.
    - Else -> RD.
  - REL: dma_req=0 for exactly one cycle -> REQ.
  - ABORT: ERR=1 -> DONE.
  - DONE: dma_req=0, RDY=1; if IE, set the irq flip-flop -> IDLE.
- If dma_ack drops mid-tenure, no strobe is issued while dma_ack=0. The FSM waits in place; its timeout counter is frozen.
- Interrupt:
  - The irq flip-flop is also set by writing IE 0->1 while RDY=1.
  - Clearing IE clears irq.
  - When istb & irq: iack=1 for one cycle with ivec=VECTOR, and irq clears. istb without irq gets no response.
- Registers update only in NEXT, so readback during a transfer shows the last committed word.

Optional Feature:
- Macro: DMA_BLOCK_MOVER_FILL_EN.
- When defined:
  - CSR bit 3 = FILL.
  - With FILL=1, the FSM skips RD/GAP1 and writes the SRC register value as the pattern to each DST word.
  - SRC and its extension do not increment.
- When undefined: bit 3 reads 0 and writes to it are ignored.

Test Plan:
- Basic copy: SRC=001000, DST=002000, WC=177775, CSR=000101, with a memory model replying in 2 cycles.
  - Expect 3 read/write pairs at 001000/002000..001004/002004.
  - Final SRC=001006, DST=002006, WC=0, CSR=000300, irq=1.
  - Pulse istb -> iack one cycle, ivec=270, irq=0.
- Burst release: BURST=4, WC=177766 (10 words).
  - dma_req low for exactly one cycle after the 4th and 8th writes.
  - No dma_stb while dma_ack=0.
- Wrap: SRC=177776 with CSR[5:4]=3, WC=177777.
  - Read at 777776; afterwards SRC=000000, CSR[5:4]=0.
- Timeout: no dma_reply.
  - 256 cycles after RD entry: ERR=1, RDY=1, dma_req=0.
  - IE=0 -> irq stays 0.
- Reset mid-transfer:
  - rst_n low during WR -> dma_stb, dma_req, irq drop asynchronously; CSR=000200.
  - bus_reset repeated -> same on the next edge.
- Fill (with DMA_BLOCK_MOVER_FILL_EN): SRC=125252, WC=177776, CSR=000011.
  - Two writes of 125252; no read cycles; SRC unchanged.
